ddram_arb: RTL and testbench
============================

// Module: ddram_arb
// PURPOSE
//  Two-requester arbiter and sequencer for the DDR3 port (DDRAM_* interface) of emu.
//  Port 0 is a read-only burst requester (video/framebuffer fetch).
//  Port 1 is a single-beat read/write requester (core/loader access).
//  One transaction is in flight at a time. Port 0 has fixed priority, with a starvation guard for port 1.
// PARAMETERS
//  P0_MAX_BURST  128  max beats per port-0 read; larger requests are clamped to this value
//  STARVE_LIMIT  8    consecutive port-0 grants while p1_req is pending before port 1 is forced
// PORTS
//  clk_sys           in   1   system clock; DDRAM_CLK is driven from it at top level
//  reset_n           in   1   asynchronous, active-low reset
//  p0_req            in   1   port-0 read request; hold high with addr/burst stable until p0_ack
//  p0_addr           in   29  port-0 64-bit word address
//  p0_burst          in   8   port-0 beat count; 0 is treated as 1
//  p0_ack            out  1   one-cycle pulse: port-0 command accepted by DDRAM
//  p0_dout           out  64  port-0 read data
//  p0_dout_valid     out  1   one pulse per returned port-0 beat
//  p1_req            in   1   port-1 request; hold high with fields stable until p1_ack
//  p1_we             in   1   1 = write, 0 = read
//  p1_addr           in   29  port-1 word address
//  p1_din            in   64  port-1 write data
//  p1_be             in   8   port-1 write byte enables
//  p1_ack            out  1   one-cycle pulse: port-1 command accepted
//  p1_dout           out  64  port-1 read data
//  p1_dout_valid     out  1   pulse for the single port-1 read beat
//  DDRAM_BUSY        in   1   waitrequest
//  DDRAM_DOUT        in   64  read data
//  DDRAM_DOUT_READY  in   1   read beat valid
//  DDRAM_RD/WE       out  1   read / write command
//  DDRAM_ADDR        out  29  command address
//  DDRAM_BURSTCNT    out  8   command burst length
//  DDRAM_DIN         out  64  write data
//  DDRAM_BE          out  8   write byte enables
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, starvation counter 0, beat counter 0.
//  - All outputs are registered.
//  - FSM states: IDLE, ISSUE, RDWAIT, DONE.
//  - IDLE:
//    - Requests are sampled at each edge.
//    - The chosen command is loaded into the DDRAM_* registers; the next state is ISSUE.
//    - Command lines are therefore active 1 cycle after req is sampled.
//  - Arbitration:
//    - p0 wins unless p1_req=1 and starve_cnt==STARVE_LIMIT; in that case p1 wins.
//    - starve_cnt increments on each p0 grant while p1_req=1.
//    - starve_cnt clears on a p1 grant or whenever p1_req=0.
//    - starve_cnt saturates at STARVE_LIMIT.
//  - ISSUE:
//    - RD/WE, ADDR, BURSTCNT, DIN and BE are held stable while DDRAM_BUSY=1.
//    - Acceptance happens at the edge where RD|WE=1 and BUSY=0.
//    - At acceptance, RD/WE drop; the owner's ack pulses in the following cycle.
//    - A read goes to RDWAIT; a write goes to DONE.
//  - Writes: BURSTCNT=1, and DIN/BE are taken from p1.
//  - Reads: DIN=0, BE=8'hFF.
//  - Burst length:
//    - p0 effective burst = max(1, min(p0_burst, P0_MAX_BURST)).
//    - p1 burst is always 1.
//  - RDWAIT:
//    - Each DDRAM_DOUT_READY cycle registers DOUT to the owner's dout.
//    - The owner's dout_valid pulses 1 cycle later.
//    - The other port's dout/valid are unaffected.
//    - After the last beat is counted, the FSM goes to IDLE.
//    - A DOUT_READY beat that coincides with the ack cycle is still counted.
//  - DONE: a single cycle in which ack is high; requests are ignored; the next state is IDLE.
//    - This prevents re-issue before the requester drops req.
//  - The requester must deassert req, or present a new command, by the cycle after ack.
//  - DOUT_READY received outside RDWAIT is ignored: no valid pulse is produced.
//  - Beat counter is 8 bits and counts up to the effective burst; it does not wrap.
//  - Reset asserted mid-operation: the async clear aborts the transaction, and no further valid pulses occur.
//    - The DDR controller may still return beats; these are ignored in IDLE.
// TESTING
//  - p0_req, addr 0x100, burst 4, BUSY=0:
//    - RD=1 for 1 cycle with ADDR=0x100 and BURSTCNT=4; p0_ack pulses once.
//    - 4 DOUT_READY beats (0xA0..0xA3) -> 4 p0_dout_valid pulses in order; then IDLE.
//  - BUSY held high 5 cycles during ISSUE:
//    - RD, ADDR and BURSTCNT are stable for 6 cycles.
//    - Exactly 1 ack is produced, 1 cycle after BUSY falls.
//  - p0_req and p1_req (write 0x55AA, BE 0x0F, addr 0x20) rise together:
//    - p0 burst is served first.
//    - Then WE=1 with BURSTCNT=1, DIN=0x55AA and BE=0x0F; p1_ack pulses.
//  - Starvation: p0_req held high continuously, p1 read pending, STARVE_LIMIT=8:
//    - The 9th grant goes to p1; its beat appears on p1_dout only.
//  - reset_n low after 2 of 4 beats:
//    - All outputs are 0 immediately.
//    - The remaining 2 DOUT_READY beats give no valid pulse.
//  - p0_burst=0 -> BURSTCNT=1 and 1 beat returned.
//  - p0_burst=200 -> BURSTCNT=128 and 128 beats returned.

Source files
------------

// File: rtl/ddram_arb.sv
// Two-requester arbiter/sequencer for the DDRAM port. Port 0 issues read bursts,
// port 1 issues single-beat reads or writes. Only one transaction is outstanding.
module ddram_arb #(
  parameter int unsigned P0_MAX_BURST = 128,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic        p0_req,
  input  logic [28:0] p0_addr,
  input  logic [7:0]  p0_burst,
  output logic        p0_ack,
  output logic [63:0] p0_dout,
  output logic        p0_dout_valid,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [28:0] p1_addr,
  input  logic [63:0] p1_din,
  input  logic [7:0]  p1_be,
  output logic        p1_ack,
  output logic [63:0] p1_dout,
  output logic        p1_dout_valid,

  input  logic        DDRAM_BUSY,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic        DDRAM_WE,
  output logic [28:0] DDRAM_ADDR,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE
);

  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [StarveW-1:0] StarveOne = StarveW'(1);
  localparam logic [7:0]         MaxBurst  = 8'(P0_MAX_BURST);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StDone} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 0 = port 0, 1 = port 1
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [7:0]          beat_q, beat_d;
  logic                rd_q, rd_d, we_q, we_d;
  logic [28:0]         addr_q, addr_d;
  logic [7:0]          burst_q, burst_d;
  logic [63:0]         din_q, din_d;
  logic [7:0]          be_q, be_d;
  logic                p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic [63:0]         p0_dout_q, p0_dout_d, p1_dout_q, p1_dout_d;
  logic                p0_valid_q, p0_valid_d, p1_valid_q, p1_valid_d;

  logic [7:0] p0_eff;
  logic [7:0] beat_inc;
  logic       p1_wins;

  assign p0_eff   = (p0_burst == 8'd0)     ? 8'd1     :
                    (p0_burst > MaxBurst)  ? MaxBurst : p0_burst;
  assign beat_inc = beat_q + 8'd1;
  // Port 1 takes the slot when port 0 is absent or port 1 has waited long enough.
  assign p1_wins  = p1_req && (!p0_req || (starve_q == StarveMax));

  // Next-state, command loading, beat routing and starvation tracking.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    beat_d     = beat_q;
    rd_d       = rd_q;
    we_d       = we_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    din_d      = din_q;
    be_d       = be_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_dout_d  = p0_dout_q;
    p1_dout_d  = p1_dout_q;
    p0_valid_d = 1'b0;
    p1_valid_d = 1'b0;

    if (!p1_req) starve_d = '0;

    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          beat_d  = 8'd0;
          state_d = StIssue;
          if (p1_wins) begin
            owner_d  = 1'b1;
            rd_d     = ~p1_we;
            we_d     = p1_we;
            addr_d   = p1_addr;
            burst_d  = 8'd1;
            din_d    = p1_we ? p1_din : 64'd0;
            be_d     = p1_we ? p1_be  : 8'hFF;
            starve_d = '0;
          end else begin
            owner_d = 1'b0;
            rd_d    = 1'b1;
            we_d    = 1'b0;
            addr_d  = p0_addr;
            burst_d = p0_eff;
            din_d   = 64'd0;
            be_d    = 8'hFF;
            if (p1_req && (starve_q != StarveMax)) starve_d = starve_q + StarveOne;
          end
        end
      end
      StIssue: begin
        if (!DDRAM_BUSY) begin
          rd_d     = 1'b0;
          we_d     = 1'b0;
          p0_ack_d = ~owner_q;
          p1_ack_d = owner_q;
          state_d  = we_q ? StDone : StRdWait;
        end
      end
      StRdWait: begin
        if (DDRAM_DOUT_READY) begin
          beat_d = beat_inc;
          if (owner_q) begin
            p1_dout_d  = DDRAM_DOUT;
            p1_valid_d = 1'b1;
          end else begin
            p0_dout_d  = DDRAM_DOUT;
            p0_valid_d = 1'b1;
          end
          if (beat_inc == burst_q) state_d = StIdle;
        end
      end
      StDone: begin
        // Ack cycle of a write; requests are not looked at until the requester drops req.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; async clear aborts any transaction.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      starve_q   <= '0;
      beat_q     <= 8'd0;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 29'd0;
      burst_q    <= 8'd0;
      din_q      <= 64'd0;
      be_q       <= 8'd0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_dout_q  <= 64'd0;
      p1_dout_q  <= 64'd0;
      p0_valid_q <= 1'b0;
      p1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      beat_q     <= beat_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      din_q      <= din_d;
      be_q       <= be_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_dout_q  <= p0_dout_d;
      p1_dout_q  <= p1_dout_d;
      p0_valid_q <= p0_valid_d;
      p1_valid_q <= p1_valid_d;
    end
  end

  assign p0_ack         = p0_ack_q;
  assign p0_dout        = p0_dout_q;
  assign p0_dout_valid  = p0_valid_q;
  assign p1_ack         = p1_ack_q;
  assign p1_dout        = p1_dout_q;
  assign p1_dout_valid  = p1_valid_q;
  assign DDRAM_RD       = rd_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_BURSTCNT = burst_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_ddram_arb.sv
// Scoreboard bench for ddram_arb: requester drivers, a DDR responder model, and
// monitors that pop expected commands/acks/beats as the DUT presents them.
module tb_ddram_arb;

  localparam int unsigned MaxBurst  = 128;
  localparam int unsigned StarveLim = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_ack, p0_dout_valid;
  logic [28:0] p0_addr;
  logic [7:0]  p0_burst;
  logic [63:0] p0_dout;
  logic        p1_req, p1_we, p1_ack, p1_dout_valid;
  logic [28:0] p1_addr;
  logic [63:0] p1_din, p1_dout;
  logic [7:0]  p1_be;
  logic        DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
  logic [63:0] DDRAM_DOUT, DDRAM_DIN;
  logic [28:0] DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;

  ddram_arb #(.P0_MAX_BURST(MaxBurst), .STARVE_LIMIT(StarveLim)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_burst(p0_burst), .p0_ack(p0_ack),
    .p0_dout(p0_dout), .p0_dout_valid(p0_dout_valid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_dout(p1_dout), .p1_dout_valid(p1_dout_valid),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        owner;
    logic        we;
    logic [28:0] addr;
    logic [7:0]  burst;
    logic [63:0] din;
    logic [7:0]  be;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [63:0] resp_q[$];
  logic [63:0] exp_p0[$];
  logic [63:0] exp_p1[$];

  int          tests = 0;
  int          fails = 0;
  bit          busy_rand = 1'b1;
  bit          fixed_en = 1'b0;
  logic [63:0] fixed_base = 64'd0;
  int          rd_cycles = 0;
  int          ack_cnt = 0;
  int          p0_vcnt = 0;
  int          starve_m = 0;
  logic [28:0] sa[10];
  logic [7:0]  sb[10];

  wire [242:0] all_out = {p0_ack, p0_dout, p0_dout_valid, p1_ack, p1_dout, p1_dout_valid,
                          DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_DIN, DDRAM_BE};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rule for the port-0 burst length.
  function automatic logic [7:0] eff_burst(input logic [7:0] b);
    if (b == 8'd0) return 8'd1;
    if (int'(b) > MaxBurst) return 8'(MaxBurst);
    return b;
  endfunction

  function automatic cmd_t p0_cmd(input logic [28:0] a, input logic [7:0] b);
    cmd_t c;
    c.owner = 1'b0; c.we = 1'b0; c.addr = a; c.burst = eff_burst(b);
    c.din = 64'd0; c.be = 8'hFF;
    return c;
  endfunction

  function automatic cmd_t p1_cmd(input logic we, input logic [28:0] a, input logic [63:0] d,
                                  input logic [7:0] be);
    cmd_t c;
    c.owner = 1'b1; c.we = we; c.addr = a; c.burst = 8'd1;
    c.din = we ? d : 64'd0; c.be = we ? be : 8'hFF;
    return c;
  endfunction

  // Command / ack monitor; a read acceptance schedules its beats with the responder.
  initial begin : cmd_mon
    bit          acc_prev = 1'b0;
    bit          acc_owner = 1'b0;
    bit          held = 1'b0;
    logic [110:0] held_vec = '0;
    logic [110:0] cur_vec;
    cmd_t        e;
    logic [63:0] d;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        acc_prev = 1'b0;
        held     = 1'b0;
      end else begin
        if (acc_prev || p0_ack || p1_ack) begin
          check("p0_ack", 256'(p0_ack), 256'(acc_prev && !acc_owner));
          check("p1_ack", 256'(p1_ack), 256'(acc_prev && acc_owner));
        end
        if (p0_ack || p1_ack) ack_cnt++;
        if (acc_prev) check("cmd_drop", 256'(DDRAM_RD | DDRAM_WE), 256'(0));
        acc_prev = 1'b0;
        if (DDRAM_RD) rd_cycles++;
        if (DDRAM_RD || DDRAM_WE) begin
          cur_vec = {DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_DIN, DDRAM_BE};
          if (held) check("cmd_stable", 256'(cur_vec), 256'(held_vec));
          if (!DDRAM_BUSY) begin
            held = 1'b0;
            check("cmd_pending", 256'(cmd_q.size() > 0), 256'(1));
            if (cmd_q.size() > 0) begin
              e = cmd_q.pop_front();
              check("cmd", 256'(cur_vec), 256'({~e.we, e.we, e.addr, e.burst, e.din, e.be}));
              acc_prev  = 1'b1;
              acc_owner = e.owner;
              if (!e.we) begin
                for (int i = 0; i < int'(e.burst); i++) begin
                  d = fixed_en ? fixed_base + 64'(i) : {$urandom, $urandom};
                  resp_q.push_back(d);
                  if (e.owner) exp_p1.push_back(d);
                  else         exp_p0.push_back(d);
                end
              end
            end
          end else begin
            held     = 1'b1;
            held_vec = cur_vec;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // Read-data monitor.
  initial begin : data_mon
    forever begin
      @(negedge clk_sys);
      if (reset_n) begin
        if (p0_dout_valid) begin
          p0_vcnt++;
          check("p0_valid_expected", 256'(exp_p0.size() > 0), 256'(1));
          if (exp_p0.size() > 0) check("p0_dout", 256'(p0_dout), 256'(exp_p0.pop_front()));
        end
        if (p1_dout_valid) begin
          check("p1_valid_expected", 256'(exp_p1.size() > 0), 256'(1));
          if (exp_p1.size() > 0) check("p1_dout", 256'(p1_dout), 256'(exp_p1.pop_front()));
        end
      end
    end
  end

  // DDR responder: random waitrequest, gapped beats, and stray beats when idle.
  initial begin : responder
    DDRAM_BUSY       = 1'b0;
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_DOUT       = 64'd0;
    forever begin
      @(posedge clk_sys);
      #1;
      DDRAM_DOUT_READY = 1'b0;
      if (busy_rand) DDRAM_BUSY = ($urandom_range(3) == 0);
      if (resp_q.size() > 0 && $urandom_range(2) != 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT       = resp_q.pop_front();
      end else if (resp_q.size() == 0 && $urandom_range(7) == 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT       = {$urandom, $urandom};
      end
    end
  end

  task automatic wait_ack(input bit port, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2000) begin
      @(negedge clk_sys);
      if (port ? p1_ack : p0_ack) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    check(port ? "p1_ack_timeout" : "p0_ack_timeout", 256'(ok), 256'(1));
    @(posedge clk_sys);
    #1;
  endtask

  task automatic p0_txn(input logic [28:0] a, input logic [7:0] b);
    bit ok;
    p0_addr = a; p0_burst = b; p0_req = 1'b1;
    wait_ack(1'b0, ok);
    p0_req = 1'b0;
  endtask

  task automatic p1_txn(input logic we, input logic [28:0] a, input logic [63:0] d,
                        input logic [7:0] be);
    bit ok;
    p1_we = we; p1_addr = a; p1_din = d; p1_be = be; p1_req = 1'b1;
    wait_ack(1'b1, ok);
    p1_req = 1'b0;
  endtask

  // Port 0 keeps req high and presents the next command right after each ack.
  task automatic p0_stream(input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      p0_addr = sa[i]; p0_burst = sb[i]; p0_req = 1'b1;
      wait_ack(1'b0, ok);
    end
    p0_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cmd_q.size() != 0 || resp_q.size() != 0 || exp_p0.size() != 0 ||
            exp_p1.size() != 0 || DDRAM_RD || DDRAM_WE) && n < 5000) begin
      @(posedge clk_sys);
      n++;
    end
    check("idle_timeout", 256'(n < 5000), 256'(1));
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  // sel: 0 = port 0 only, 1 = port 1 only, 2 = both raised in the same cycle.
  task automatic run_round(input int sel, input logic [28:0] a0, input logic [7:0] b0,
                           input logic we1, input logic [28:0] a1, input logic [63:0] d1,
                           input logic [7:0] be1);
    // With both fresh, port 1 has not waited yet, so port 0 goes first.
    if (sel != 1) cmd_q.push_back(p0_cmd(a0, b0));
    if (sel != 0) cmd_q.push_back(p1_cmd(we1, a1, d1, be1));
    fork
      begin if (sel != 1) p0_txn(a0, b0); end
      begin if (sel != 0) p1_txn(we1, a1, d1, be1); end
    join
    wait_idle();
  endtask

  initial begin : main
    int  n;
    int  np0;
    bit  p1_pend;
    int  snap;
    reset_n = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p0_burst = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_din = '0; p1_be = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs", 256'(all_out), 256'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // Basic burst-4 read with no waitrequest and known data.
    busy_rand = 1'b0; DDRAM_BUSY = 1'b0;
    fixed_en = 1'b1; fixed_base = 64'hA0;
    rd_cycles = 0; ack_cnt = 0;
    run_round(0, 29'h100, 8'd4, 1'b0, '0, '0, '0);
    check("basic_rd_cycles", 256'(rd_cycles), 256'(1));
    check("basic_ack_cnt", 256'(ack_cnt), 256'(1));
    fixed_en = 1'b0;

    // Waitrequest held for 5 cycles of the issue phase.
    DDRAM_BUSY = 1'b1;
    rd_cycles = 0; ack_cnt = 0;
    cmd_q.push_back(p0_cmd(29'h40, 8'd2));
    fork
      p0_txn(29'h40, 8'd2);
      begin
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!DDRAM_RD && n < 50);
        check("busy_rd_seen", 256'(DDRAM_RD), 256'(1));
        repeat (4) @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
        DDRAM_BUSY = 1'b0;
      end
    join
    wait_idle();
    check("busy_rd_cycles", 256'(rd_cycles), 256'(6));
    check("busy_ack_cnt", 256'(ack_cnt), 256'(1));
    busy_rand = 1'b1;

    // Simultaneous burst read and port-1 write.
    run_round(2, 29'h180, 8'd3, 1'b1, 29'h20, 64'h55AA, 8'h0F);

    // Burst-length boundaries.
    run_round(0, 29'h200, 8'd0, 1'b0, '0, '0, '0);
    run_round(0, 29'h400, 8'd200, 1'b0, '0, '0, '0);
    run_round(0, 29'h600, 8'd128, 1'b0, '0, '0, '0);

    // Starvation: port 0 streams 10 reads, port 1 read pending from the start.
    for (int i = 0; i < 10; i++) begin
      sa[i] = 29'($urandom);
      sb[i] = 8'($urandom_range(4));
    end
    starve_m = 0; np0 = 0; p1_pend = 1'b1;
    while (np0 < 10 || p1_pend) begin
      if (p1_pend && (starve_m == StarveLim || np0 == 10)) begin
        cmd_q.push_back(p1_cmd(1'b0, 29'h3F0, 64'd0, 8'd0));
        p1_pend  = 1'b0;
        starve_m = 0;
      end else begin
        cmd_q.push_back(p0_cmd(sa[np0], sb[np0]));
        np0++;
        if (p1_pend && starve_m < StarveLim) starve_m++;
      end
    end
    fork
      p0_stream(10);
      p1_txn(1'b0, 29'h3F0, 64'd0, 8'd0);
    join
    wait_idle();

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      int          sel;
      logic [7:0]  b0;
      sel = $urandom_range(2);
      b0  = ($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(8));
      run_round(sel, 29'($urandom), b0, 1'($urandom), 29'($urandom), {$urandom, $urandom},
                8'($urandom));
    end

    // Reset in the middle of a burst-4 read.
    cmd_q.push_back(p0_cmd(29'h300, 8'd4));
    snap = p0_vcnt;
    p0_txn(29'h300, 8'd4);
    n = 0;
    while (p0_vcnt < snap + 2 && n < 500) begin
      @(posedge clk_sys);
      n++;
    end
    check("midrst_two_beats", 256'(p0_vcnt >= snap + 2), 256'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", 256'(all_out), 256'(0));
    cmd_q.delete();
    exp_p0.delete();
    exp_p1.delete();
    snap = p0_vcnt;
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    wait_idle();
    repeat (10) @(posedge clk_sys);
    #1;
    check("midrst_no_valid", 256'(p0_vcnt), 256'(snap));

    // Port still usable after the abort.
    run_round(1, '0, '0, 1'b0, 29'h1234, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
